// File: rtl/virtio_pkg.sv
// Purpose: shared types, constants and address helper for the virtqueue notify scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package virtio_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2,
    WAIT = 2'd3
  } vq_state_e;

  localparam int          VIRTIO_PAGE_SHIFT = 12;
  localparam logic [15:0] AVAIL_HDR_LEN     = 16'd4;

  // Legacy layout: the avail ring follows the 16-byte descriptor table entries.
  function automatic logic [63:0] avail_addr(input logic [31:0] pfn, input int unsigned qsize);
    return ({32'h0, pfn} << VIRTIO_PAGE_SHIFT) + 64'(16 * qsize);
  endfunction

endpackage

// File: rtl/vq_rr_arbiter.sv
// Purpose: round-robin pick of the first pending queue at or above rr_ptr, with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module vq_rr_arbiter
  import virtio_pkg::*;
#(
  parameter  int NUM_Q = 3,
  localparam int QW    = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic [NUM_Q-1:0] pending,
  input  logic [QW-1:0]    rr_ptr,
  output logic [NUM_Q-1:0] gnt_oh,
  output logic [QW-1:0]    gnt_idx,
  output logic             gnt_any
);

  // rr_ptr is always below NUM_Q, so a single subtraction implements the modulo.
  function automatic logic [QW-1:0] wrap_idx(input logic [QW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_Q) s = s - NUM_Q;
    return QW'(s);
  endfunction

  // Scan NUM_Q positions starting at rr_ptr; the first pending one wins.
  always_comb begin
    logic [QW-1:0] idx;
    idx     = '0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_Q; i++) begin
      idx = wrap_idx(rr_ptr, i);
      if (!gnt_any && pending[idx]) begin
        gnt_any     = 1'b1;
        gnt_idx     = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/virtio_vq_notify_sched.sv
// Purpose: turn Queue Notify writes into one-at-a-time avail-header DMA reads, round-robin over queues.
// Latency: notify to req_valid is 3 edges from idle (capture, IDLE->ARB, ARB->REQ).
// Backpressure: req held stable until req_ready; no new request until done_valid for the in-flight queue or timeout.
module virtio_vq_notify_sched
  import virtio_pkg::*;
#(
  parameter int NUM_Q       = 3,
  parameter int QSIZE       = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clka,
  input  logic                 rst,
  input  logic                 soft_rst,
  input  logic                 drv_ok,
  input  logic                 notify_valid,
  input  logic [15:0]          notify_qidx,
  input  logic [32*NUM_Q-1:0]  qpfn,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [15:0]          req_qidx,
  output logic [63:0]          req_addr,
  output logic [15:0]          req_len,
  input  logic                 done_valid,
  input  logic [15:0]          done_qidx,
  output logic [NUM_Q-1:0]     pending,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          drop_cnt
);

  localparam int            QW      = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int            TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  vq_state_e        state;
  logic [QW-1:0]    rr_ptr;
  logic [TW-1:0]    wait_cnt;
  logic [NUM_Q-1:0] set_mask;
  logic [NUM_Q-1:0] clr_mask;
  logic [NUM_Q-1:0] gnt_oh;
  logic [QW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             notify_drop;
  logic [31:0]      sel_pfn;

  assign busy    = (state != IDLE);
  assign req_len = AVAIL_HDR_LEN;

  vq_rr_arbiter #(.NUM_Q(NUM_Q)) u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Decode a notify: in-range queue with a programmed PFN sets its flag, anything else is a drop.
  always_comb begin
    set_mask = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      if (notify_valid && (notify_qidx == 16'(q)) && (qpfn[q*32 +: 32] != 32'h0))
        set_mask[q] = 1'b1;
    end
    notify_drop = notify_valid && (set_mask == '0);
  end

  // PFN of the granted queue, and the flag ARB consumes this cycle.
  always_comb begin
    sel_pfn = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      if (gnt_oh[q]) sel_pfn = qpfn[q*32 +: 32];
    end
    clr_mask = (state == ARB) ? gnt_oh : '0;
  end

  // Pending flags (a same-cycle set beats the ARB clear) and saturating drop counter.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else if (soft_rst) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (notify_drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Request FSM with registered request outputs, rr pointer and WAIT timeout.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_valid   <= 1'b0;
      req_qidx    <= '0;
      req_addr    <= '0;
      rr_ptr      <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else if (soft_rst) begin
      state       <= IDLE;
      req_valid   <= 1'b0;
      req_qidx    <= '0;
      req_addr    <= '0;
      rr_ptr      <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|pending) && drv_ok) state <= ARB;
        end
        ARB: begin
          if (gnt_any) begin
            state     <= REQ;
            req_valid <= 1'b1;
            req_qidx  <= 16'(gnt_idx);
            req_addr  <= avail_addr(sel_pfn, QSIZE);
            rr_ptr    <= (gnt_idx == QW'(NUM_Q - 1)) ? '0 : gnt_idx + QW'(1);
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Completions for other queues are not ours; only the latched queue ends the wait.
          if (done_valid && (done_qidx == req_qidx)) begin
            state <= IDLE;
          end else if ((TIMEOUT_CYC != 0) && (wait_cnt == TO_LAST)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_virtio_vq_notify_sched.sv
// Purpose: self-checking bench for virtio_vq_notify_sched (vector table + request scoreboard).
// Latency: inputs change 2 time units after posedge; outputs sampled at negedge or 2 units after posedge.
// Backpressure: req_ready driven explicitly per sequence to exercise stalls.
module tb_virtio_vq_notify_sched;

  localparam int NUM_Q = 3;

  logic               clka = 1'b0;
  logic               rst;
  logic               soft_rst;
  logic               drv_ok;
  logic               notify_valid;
  logic [15:0]        notify_qidx;
  logic [32*NUM_Q-1:0] qpfn;
  logic               req_valid;
  logic               req_ready;
  logic [15:0]        req_qidx;
  logic [63:0]        req_addr;
  logic [15:0]        req_len;
  logic               done_valid;
  logic [15:0]        done_qidx;
  logic [NUM_Q-1:0]   pending;
  logic               busy;
  logic               timeout_err;
  logic [15:0]        drop_cnt;

  virtio_vq_notify_sched #(.NUM_Q(NUM_Q), .QSIZE(256), .TIMEOUT_CYC(1024)) dut (
    .clka         (clka),
    .rst          (rst),
    .soft_rst     (soft_rst),
    .drv_ok       (drv_ok),
    .notify_valid (notify_valid),
    .notify_qidx  (notify_qidx),
    .qpfn         (qpfn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_qidx     (req_qidx),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .done_valid   (done_valid),
    .done_qidx    (done_qidx),
    .pending      (pending),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .drop_cnt     (drop_cnt)
  );

  always #5 clka = ~clka;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [15:0] q;
    logic [63:0] addr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [15:0] q;
    logic [31:0] pfn;
    bit          req;
    logic [63:0] addr;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] q, input logic [63:0] a);
    exp_t e;
    e.q    = q;
    e.addr = a;
    sb.push_back(e);
  endtask

  // Every accepted request is compared against the oldest outstanding expectation.
  always @(negedge clka) begin
    if (req_valid === 1'b1 && req_ready === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_req: got q%0d addr %0h want no request", req_qidx, req_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("req_qidx", 64'(req_qidx), 64'(mon_e.q));
        chk("req_addr", req_addr, mon_e.addr);
        chk("req_len", 64'(req_len), 64'd4);
      end
    end
  end

  task automatic step();
    @(posedge clka);
    #2;
  endtask

  task automatic set_pfn(input int q, input logic [31:0] p);
    qpfn[q*32 +: 32] = p;
  endtask

  task automatic notify(input logic [15:0] q);
    notify_valid = 1'b1;
    notify_qidx  = q;
    step();
    notify_valid = 1'b0;
  endtask

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL wait_req: req_valid=0 after 40 cycles, want 1");
    end
  endtask

  task automatic handshake();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
  endtask

  task automatic done(input logic [15:0] q);
    done_valid = 1'b1;
    done_qidx  = q;
    step();
    done_valid = 1'b0;
  endtask

  task automatic serve(input logic [15:0] q);
    wait_req();
    handshake();
    done(q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_drop;
    bit  went_idle;

    rst          = 1'b1;
    soft_rst     = 1'b0;
    drv_ok       = 1'b0;
    notify_valid = 1'b0;
    notify_qidx  = '0;
    qpfn         = '0;
    req_ready    = 1'b0;
    done_valid   = 1'b0;
    done_qidx    = '0;

    vt[0] = vec_t'{16'd0, 32'h0000_0001, 1'b1, 64'h0000_0000_0000_2000};
    vt[1] = vec_t'{16'd2, 32'h000A_BCDE, 1'b1, 64'h0000_0000_ABCD_F000};
    vt[2] = vec_t'{16'd1, 32'hFFFF_FFFF, 1'b1, 64'h0000_1000_0000_0000};
    vt[3] = vec_t'{16'd5, 32'h0000_1234, 1'b0, 64'h0};
    vt[4] = vec_t'{16'd0, 32'h0000_0000, 1'b0, 64'h0};
    vt[5] = vec_t'{16'd1, 32'h0000_0012, 1'b1, 64'h0000_0000_0001_3000};

    // Reset values
    #12;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_qidx", 64'(req_qidx), 64'd0);
    chk("rst_req_addr", req_addr, 64'd0);
    chk("rst_req_len", 64'(req_len), 64'd4);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    step();
    rst    = 1'b0;
    drv_ok = 1'b1;
    step();

    // Latency: notify q1 -> req_valid after capture, IDLE->ARB, ARB->REQ
    set_pfn(1, 32'h0000_0012);
    step();
    push(16'd1, 64'h13000);
    notify_valid = 1'b1;
    notify_qidx  = 16'd1;
    step();
    notify_valid = 1'b0;
    chk("lat_e1_pending", 64'(pending), 64'b010);
    chk("lat_e1_req_valid", 64'(req_valid), 64'd0);
    step();
    chk("lat_e2_busy", 64'(busy), 64'd1);
    chk("lat_e2_req_valid", 64'(req_valid), 64'd0);
    step();
    chk("lat_e3_req_valid", 64'(req_valid), 64'd1);
    chk("lat_e3_pending", 64'(pending), 64'd0);
    handshake();
    done(16'd1);

    // Vector table: one notify each, either a request or a drop
    exp_drop = 0;
    for (int i = 0; i < 6; i++) begin
      if (vt[i].q < 16'd3) set_pfn(int'(vt[i].q), vt[i].pfn);
      step();
      if (vt[i].req) push(vt[i].q, vt[i].addr);
      else exp_drop++;
      notify(vt[i].q);
      if (vt[i].req) begin
        serve(vt[i].q);
      end else begin
        repeat (5) step();
        chk("vec_no_req_valid", 64'(req_valid), 64'd0);
        chk("vec_no_req_busy", 64'(busy), 64'd0);
      end
      chk("vec_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      chk("vec_pending", 64'(pending), 64'd0);
    end

    // Round-robin: serve q0 so the pointer sits at q1, then pend q0 and q2 together
    set_pfn(0, 32'h0000_0001);
    step();
    push(16'd0, 64'h2000);
    notify(16'd0);
    serve(16'd0);
    drv_ok = 1'b0;
    step();
    notify(16'd0);
    notify(16'd2);
    repeat (3) step();
    chk("rr_pending_held", 64'(pending), 64'b101);
    chk("rr_busy_drv_off", 64'(busy), 64'd0);
    push(16'd2, 64'hABCD_F000);
    push(16'd0, 64'h2000);
    drv_ok = 1'b1;
    wait_req();
    handshake();
    push(16'd2, 64'hABCD_F000);
    notify(16'd2);
    chk("rr_repend", 64'(pending), 64'b101);
    done(16'd2);
    serve(16'd0);
    serve(16'd2);

    // Notify lands on the same edge ARB clears that queue: flag survives
    step();
    push(16'd1, 64'h13000);
    notify_valid = 1'b1;
    notify_qidx  = 16'd1;
    step();
    notify_valid = 1'b0;
    step();
    push(16'd1, 64'h13000);
    notify_valid = 1'b1;
    step();
    notify_valid = 1'b0;
    chk("setwins_req_valid", 64'(req_valid), 64'd1);
    chk("setwins_pending", 64'(pending), 64'b010);
    handshake();
    done(16'd1);
    serve(16'd1);

    // Stall: request stays put with req_ready low; re-notify during WAIT refetches
    step();
    push(16'd1, 64'h13000);
    notify(16'd1);
    wait_req();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", 64'(req_valid), 64'd1);
      chk("stall_addr", req_addr, 64'h13000);
      chk("stall_qidx", 64'(req_qidx), 64'd1);
    end
    handshake();
    push(16'd1, 64'h13000);
    notify(16'd1);
    chk("wait_repend", 64'(pending), 64'b010);
    done(16'd2);
    chk("wait_ignore_other_done", 64'(busy), 64'd1);
    done(16'd1);
    serve(16'd1);

    // Timeout: no completion for TIMEOUT_CYC cycles
    step();
    push(16'd0, 64'h2000);
    notify(16'd0);
    wait_req();
    handshake();
    repeat (1000) step();
    chk("to_early_busy", 64'(busy), 64'd1);
    chk("to_early_err", 64'(timeout_err), 64'd0);
    went_idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) begin
        went_idle = 1'b1;
        break;
      end
      step();
    end
    chk("to_went_idle", 64'(went_idle), 64'd1);
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_pending", 64'(pending), 64'd0);
    done(16'd0);
    step();
    chk("to_stray_done_busy", 64'(busy), 64'd0);

    // soft_rst while a request is presented (the request is abandoned, never accepted)
    notify(16'd2);
    wait_req();
    notify(16'd0);
    chk("srst_pre_pending", 64'(pending), 64'b001);
    chk("srst_pre_drop", 64'(drop_cnt), 64'd2);
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    chk("srst_req_valid", 64'(req_valid), 64'd0);
    chk("srst_pending", 64'(pending), 64'd0);
    chk("srst_drop", 64'(drop_cnt), 64'd0);
    chk("srst_timeout", 64'(timeout_err), 64'd0);
    chk("srst_busy", 64'(busy), 64'd0);
    done(16'd2);
    repeat (3) step();
    chk("srst_stray_busy", 64'(busy), 64'd0);
    chk("srst_stray_valid", 64'(req_valid), 64'd0);

    // Async reset in WAIT with other state populated
    notify(16'd7);
    push(16'd1, 64'h13000);
    notify(16'd1);
    wait_req();
    handshake();
    notify(16'd0);
    chk("arst_pre_busy", 64'(busy), 64'd1);
    chk("arst_pre_drop", 64'(drop_cnt), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_req_valid", 64'(req_valid), 64'd0);
    chk("arst_req_qidx", 64'(req_qidx), 64'd0);
    chk("arst_req_addr", req_addr, 64'd0);
    chk("arst_req_len", 64'(req_len), 64'd4);
    chk("arst_pending", 64'(pending), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_timeout", 64'(timeout_err), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Normal operation resumes after reset
    push(16'd1, 64'h13000);
    notify(16'd1);
    serve(16'd1);
    repeat (2) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
